alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Instruction fetch/decode/issue sequencer for the t258 16-bit datapath. It is the driving end of the ALU interface.
- Fetches instruction words over a request/valid handshake, decodes them, and holds an 8x16 register file.
- Presents operands and an ALU op code to the external combinational ALU, then writes the ALU result back.
- Also handles immediate load, branch, jump and halt.

Parameters:
DATA_W, 16, datapath/register width
PC_W, 12, program counter / instruction address width
NREGS, 8, register file depth (fixed 3-bit index)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held high until accepted
imem_addr  out  PC_W  fetch address (= pc)
imem_valid  in  1  instruction word valid; accepted only while imem_req=1
imem_rdata  in  16  instruction word
alu_a  out  DATA_W  ALU operand a
alu_b  out  DATA_W  ALU operand b
alu_op  out  4  ALU op code (ALU_OP_* values)
alu_result  in  DATA_W  ALU combinational result
pc  out  PC_W  current PC
instr_done  out  1  one-cycle pulse per retired instruction
halted  out  1  sticky halt flag
dbg_sel  in  3  debug register select
dbg_data  out  DATA_W  combinational read of reg[dbg_sel]

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state IDLE, pc=RESET_PC.
  - imem_req=0, alu_a=0, alu_b=0, alu_op=ALU_OP_LD.
  - instr_done=0, halted=0, all registers 0.
- Instruction format: [15:12] opc, [11:9] rd, [8:6] rs, [5:3] rt, [8:0] imm9, [11:0] imm12.
- Opcode to ALU op (alu_a=reg[rs], alu_b=reg[rt], result written to reg[rd]):
  - 1 ADD, 2 SUB, 3 MUL, 4 OR, 5 AND, 6 XOR, 7 CMP, 8 LESSTHAN.
  - 9 INC, A DEC: b unused, driven 0.
  - B MOV: ALU_OP_LD, b=reg[rs].
  - C LDI: ALU_OP_LD, b=zero-extended imm9.
- Control opcodes, no ALU use:
  - 0 NOP.
  - D BNZ: if reg[rd]!=0, pc=pc+1+sext(imm9); otherwise pc+1.
  - E JMP: pc=imm12[PC_W-1:0].
  - F HALT.
- FSM:
  - IDLE -> FETCH unconditionally on the first clock after reset.
  - FETCH: imem_req=1, imem_addr=pc. If imem_valid=1 in a cycle where imem_req=1, latch imem_rdata, drop imem_req, go to DECODE. Otherwise stay in FETCH, with req held.
  - DECODE: read registers; register alu_a/alu_b/alu_op; go to EXEC. HALT goes to HALT instead.
  - EXEC: ALU inputs are stable; capture alu_result into a writeback register at the end of the cycle; go to WB.
  - WB: write reg[rd] for ALU opcodes; update pc; pulse instr_done=1; go to FETCH.
  - HALT: halted=1, instr_done pulses once on entry, imem_req=0. Exits only on reset.
- Latency: 4 cycles per instruction with zero-wait memory (valid in the first FETCH cycle). Each memory wait cycle adds 1.
- Width rules:
  - Results are the low DATA_W bits as returned by the ALU. No flags are kept.
  - pc arithmetic is modulo 2^PC_W: 0xFFF+1 -> 0x000, and negative branch offsets wrap.
- Hazards: a register written in WB is read by the next instruction's DECODE, which occurs at least 2 cycles later. No forwarding is needed; the next instruction sees the new value.
- alu_a/alu_b/alu_op hold their last values outside EXEC. They are don't-care for NOP/BNZ/JMP/HALT.
- imem_valid while imem_req=0 is ignored.
- Reset asserted mid-operation: all state returns to reset values immediately. An in-flight fetch is abandoned and the pending register write is discarded.

Decomposition:
- Shared package/header const.vh:
  - ALU_OP_* codes (already present).
  - Add OPC_* instruction opcodes, field bit positions, and FSM state encodings.
- One natural sub-module: issue_regfile. It is 8x16, with 2 synchronous-write / combinational-read ports plus the debug read port, and is reset to 0 asynchronously.

Test Plan:
- LDI r1,5; LDI r2,7; ADD r3,r1,r2 -> dbg r3=0x000C; alu_op=ALU_OP_ADD during EXEC; instr_done pulses 3 times, 4 cycles apart, with zero-wait memory.
- LDI r1,0x1FF; MUL r2,r1,r1 -> r2=0xFC01 (low 16 bits of 0x3FC01); DEC r4,r0 -> r4=0xFFFF.
- Loop: LDI r1,3; DEC r1,r1; BNZ r1,-2 -> body executes 3 times, final r1=0, pc ends at the BNZ address+1.
- JMP 0xFFF with HALT at 0xFFF -> pc=0xFFF, then halted=1; imem_req stays 0 for 20 cycles. A variant with NOP at 0xFFF gives pc=0x000.
- Memory stalls of 0, 1 and 5 cycles: imem_req is held until imem_valid, and the addr stays stable; results are identical to the zero-wait run.
- Deassert rst_n during EXEC of ADD r3 -> r3 is not written, pc=0, halted=0, imem_req=0. Execution restarts at RESET_PC after release.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the t258 fetch/decode/issue sequencer:
//   - ALU_OP_* codes driven on alu_op towards the external ALU
//   - OPC_* instruction opcodes and instruction field bit positions
//   - sequencer FSM state encoding
//   - helpers mapping an opcode to its ALU behaviour
// ---------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

   // ALU operation codes understood by the external combinational ALU
   localparam logic [3:0] ALU_OP_LD       = 4'h0;   // result = b
   localparam logic [3:0] ALU_OP_ADD      = 4'h1;
   localparam logic [3:0] ALU_OP_SUB      = 4'h2;
   localparam logic [3:0] ALU_OP_MUL      = 4'h3;
   localparam logic [3:0] ALU_OP_OR       = 4'h4;
   localparam logic [3:0] ALU_OP_AND      = 4'h5;
   localparam logic [3:0] ALU_OP_XOR      = 4'h6;
   localparam logic [3:0] ALU_OP_CMP      = 4'h7;
   localparam logic [3:0] ALU_OP_LESSTHAN = 4'h8;
   localparam logic [3:0] ALU_OP_INC      = 4'h9;
   localparam logic [3:0] ALU_OP_DEC      = 4'hA;

   // Instruction opcodes (ir[15:12])
   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_ADD  = 4'h1;
   localparam logic [3:0] OPC_SUB  = 4'h2;
   localparam logic [3:0] OPC_MUL  = 4'h3;
   localparam logic [3:0] OPC_OR   = 4'h4;
   localparam logic [3:0] OPC_AND  = 4'h5;
   localparam logic [3:0] OPC_XOR  = 4'h6;
   localparam logic [3:0] OPC_CMP  = 4'h7;
   localparam logic [3:0] OPC_LT   = 4'h8;
   localparam logic [3:0] OPC_INC  = 4'h9;
   localparam logic [3:0] OPC_DEC  = 4'hA;
   localparam logic [3:0] OPC_MOV  = 4'hB;
   localparam logic [3:0] OPC_LDI  = 4'hC;
   localparam logic [3:0] OPC_BNZ  = 4'hD;
   localparam logic [3:0] OPC_JMP  = 4'hE;
   localparam logic [3:0] OPC_HALT = 4'hF;

   // Instruction field positions
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS_HI  = 8;
   localparam int RS_LO  = 6;
   localparam int RT_HI  = 5;
   localparam int RT_LO  = 3;
   localparam int IMM9_W = 9;
   localparam int IMM12_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   // Opcodes whose result is written back to reg[rd]
   function automatic logic is_alu_opc(input logic [3:0] opc);
      return (opc >= OPC_ADD) && (opc <= OPC_LDI);
   endfunction

   // Opcode -> ALU op; MOV/LDI are plain loads of operand b
   function automatic logic [3:0] alu_op_of(input logic [3:0] opc);
      logic [3:0] op;
      op = ALU_OP_LD;
      case (opc)
         OPC_ADD: op = ALU_OP_ADD;
         OPC_SUB: op = ALU_OP_SUB;
         OPC_MUL: op = ALU_OP_MUL;
         OPC_OR:  op = ALU_OP_OR;
         OPC_AND: op = ALU_OP_AND;
         OPC_XOR: op = ALU_OP_XOR;
         OPC_CMP: op = ALU_OP_CMP;
         OPC_LT:  op = ALU_OP_LESSTHAN;
         OPC_INC: op = ALU_OP_INC;
         OPC_DEC: op = ALU_OP_DEC;
         default: op = ALU_OP_LD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_regfile
// NREGS x DATA_W register file, asynchronously cleared.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   we, waddr, wdata      synchronous write port
//   ra_addr / ra_data     combinational read port a
//   rb_addr / rb_data     combinational read port b
//   dbg_addr / dbg_data   combinational debug read port
// ---------------------------------------------------------------------------
module alu_issue_ctrl_regfile #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [AW-1:0]     rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign ra_data  = regs[ra_addr];
   assign rb_data  = regs[rb_addr];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Fetch/decode/issue sequencer driving an external combinational ALU.
// One instruction per FETCH -> DECODE -> EXEC -> WB pass (HALT stops after
// DECODE). Outputs towards memory and ALU are registered.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req/imem_addr       fetch request (held until accepted) and address
//   imem_valid/imem_rdata    fetch response, only honoured while imem_req=1
//   alu_a/alu_b/alu_op       ALU operands and op code (hold outside EXEC)
//   alu_result               ALU combinational result
//   pc                       current program counter
//   instr_done               one-cycle pulse per retired instruction
//   halted                   sticky halt flag (cleared only by reset)
//   dbg_sel/dbg_data         combinational debug register read
// ---------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int PC_W     = 12,
   parameter int NREGS    = 8,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_valid,
   input  logic [15:0]       imem_rdata,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   output logic [PC_W-1:0]   pc,
   output logic              instr_done,
   output logic              halted,
   input  logic [2:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

   state_t            state_reg;
   logic [PC_W-1:0]   pc_reg;
   logic [15:0]       ir_reg;
   logic [DATA_W-1:0] wb_data_reg;
   logic [DATA_W-1:0] alu_a_reg;
   logic [DATA_W-1:0] alu_b_reg;
   logic [3:0]        alu_op_reg;
   logic              imem_req_reg;
   logic              instr_done_reg;
   logic              halted_reg;
   logic              br_taken_reg;

   // Instruction fields
   logic [3:0]         opc;
   logic [2:0]         rd, rs, rt;
   logic [IMM9_W-1:0]  imm9;
   logic [IMM12_W-1:0] imm12;

   assign opc   = ir_reg[OPC_HI:OPC_LO];
   assign rd    = ir_reg[RD_HI:RD_LO];
   assign rs    = ir_reg[RS_HI:RS_LO];
   assign rt    = ir_reg[RT_HI:RT_LO];
   assign imm9  = ir_reg[IMM9_W-1:0];
   assign imm12 = ir_reg[IMM12_W-1:0];

   // Register file: port a reads rd for BNZ (condition), rs otherwise
   logic [2:0]        ra_addr;
   logic [DATA_W-1:0] ra_data, rb_data;
   logic              wr_en;

   assign ra_addr = (opc == OPC_BNZ) ? rd : rs;
   assign wr_en   = (state_reg == ST_WB) && is_alu_opc(opc);

   alu_issue_ctrl_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wr_en),
      .waddr    (rd),
      .wdata    (wb_data_reg),
      .ra_addr  (ra_addr),
      .ra_data  (ra_data),
      .rb_addr  (rt),
      .rb_data  (rb_data),
      .dbg_addr (dbg_sel),
      .dbg_data (dbg_data)
   );

   // Operand b selection for the issued ALU op
   logic [DATA_W-1:0] dec_b;
   always_comb begin
      dec_b = rb_data;
      case (opc)
         OPC_INC, OPC_DEC: dec_b = '0;
         OPC_MOV:          dec_b = ra_data;
         OPC_LDI:          dec_b = {{(DATA_W-IMM9_W){1'b0}}, imm9};
         default:          dec_b = rb_data;
      endcase
   end

   // Next PC, modulo 2^PC_W; branch offset is relative to pc+1
   logic [PC_W-1:0] pc_inc, br_off, pc_next;
   assign pc_inc = pc_reg + PC_W'(1);
   assign br_off = {{(PC_W-IMM9_W){imm9[IMM9_W-1]}}, imm9};

   always_comb begin
      pc_next = pc_inc;
      case (opc)
         OPC_BNZ: if (br_taken_reg) pc_next = pc_inc + br_off;
         OPC_JMP: pc_next = imm12[PC_W-1:0];
         default: pc_next = pc_inc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         pc_reg         <= PC_RST;
         ir_reg         <= '0;
         wb_data_reg    <= '0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         alu_op_reg     <= ALU_OP_LD;
         imem_req_reg   <= 1'b0;
         instr_done_reg <= 1'b0;
         halted_reg     <= 1'b0;
         br_taken_reg   <= 1'b0;
      end else begin
         instr_done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               imem_req_reg <= 1'b1;
               state_reg    <= ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_req_reg && imem_valid) begin
                  ir_reg       <= imem_rdata;
                  imem_req_reg <= 1'b0;
                  state_reg    <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (opc == OPC_HALT) begin
                  halted_reg     <= 1'b1;
                  instr_done_reg <= 1'b1;
                  state_reg      <= ST_HALT;
               end else begin
                  // Non-ALU opcodes leave the ALU inputs untouched
                  if (is_alu_opc(opc)) begin
                     alu_a_reg  <= ra_data;
                     alu_b_reg  <= dec_b;
                     alu_op_reg <= alu_op_of(opc);
                  end
                  br_taken_reg <= (ra_data != '0);
                  state_reg    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               wb_data_reg    <= alu_result;
               instr_done_reg <= 1'b1;     // high during WB
               state_reg      <= ST_WB;
            end
            ST_WB: begin
               pc_reg       <= pc_next;
               imem_req_reg <= 1'b1;
               state_reg    <= ST_FETCH;
            end
            ST_HALT: begin
               state_reg <= ST_HALT;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign imem_req   = imem_req_reg;
   assign imem_addr  = pc_reg;
   assign pc         = pc_reg;
   assign alu_a      = alu_a_reg;
   assign alu_b      = alu_b_reg;
   assign alu_op     = alu_op_reg;
   assign instr_done = instr_done_reg;
   assign halted     = halted_reg;

endmodule
